arbiter_rr_merge: RTL
=====================

Name: arbiter_rr_merge

Overview:
- N-to-1 round-robin arbiter that merges N valid/ready input streams onto one output channel.
- It is the inverse of the address-demux router: the winning input's index is prepended as the MSBs of the outgoing message, so a downstream router can steer replies back by source.
- Has a single-entry registered output stage (1-cycle latency, full throughput).
- Sits at the merge side of the packet interconnect, sharing one link between N requesters.

Parameters:
- p_nbits, 32, width of each input message.
- p_ninputs, 8, number of requesters; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid  input  1 x [0:p_ninputs-1]  per-input request valid.
- message_in  input  p_nbits x [0:p_ninputs-1]  per-input payload.
- ready_out  output  1 x [0:p_ninputs-1]  per-input accept; combinational.
- valid_out  output  1  output stage holds a message.
- ready  input  1  downstream accept.
- message_out  output  p_nbits+$clog2(p_ninputs)  {source index, payload}; registered.

Behaviour:
- State:
  - out_valid_q (drives valid_out)
  - out_msg_q (drives message_out)
  - priority pointer ptr_q, $clog2(p_ninputs) bits
- Reset (async assert, takes effect immediately): valid_out=0, message_out=0, ptr_q=0. ready_out follows from the combinational rules below, so every ready_out[i]=0 while reset is high.
- Grant (combinational): g = first index i with valid[i]=1, searching ptr_q, ptr_q+1, ..., wrapping modulo p_ninputs. No grant if no input is valid.
- can_load = !valid_out || ready.
- ready_out[i] = !reset && can_load && (i == g). At most one ready_out is high in any cycle. ready_out may depend combinationally on valid and ready; no input sees ready_out without its own valid.
- Accept: valid[g] && ready_out[g] at a clock edge. On accept:
  - out_msg_q <= {g, message_in[g]}
  - valid_out <= 1
  - ptr_q <= (g+1) mod p_ninputs
- Drain: valid_out && ready at an edge with no accept: valid_out <= 0. message_out keeps its last value and is don't-care while valid_out=0.
- Simultaneous drain and accept in the same cycle: the old message leaves and the new one loads. This sustains one message per cycle.
- Stall: valid_out=1 && ready=0: can_load=0, all ready_out=0, out_msg_q and ptr_q hold. A held output message is never overwritten or reordered.
- ptr_q changes only on accept. Idle cycles and stalled cycles leave the pointer unchanged.
- Fairness: with all inputs continuously valid and ready=1, grants cycle 0,1,...,N-1,0,...; each input waits at most N-1 grants.
- Latency: accepted at edge t, visible on valid_out/message_out after edge t.
- Reset mid-operation: any held message is discarded and the pointer returns to 0. There are no partial transfers.
- Input payload is not registered before accept. Inputs must hold message_in stable while valid and not accepted; the arbiter does not check this.

Test Plan (p_nbits=8, p_ninputs=4; message_out is 10 bits):
1. Reset, then apply no valids -> valid_out=0, message_out=0, all ready_out=0, ptr stays 0.
2. Single request: valid[2]=1, message_in[2]=8'hA5, ready=1 -> ready_out[2]=1 in the same cycle; next cycle valid_out=1, message_out=10'b10_10100101. A following read of ptr shows next-priority index 3.
3. All four valid continuously, ready=1, message_in[i]=8'h10+i -> accepted order 0,1,2,3,0. Outputs are 10'h010, 10'h111, 10'h212, 10'h313, 10'h010, one per cycle with no bubbles.
4. Backpressure: fill output with input 1 (8'h3C), hold ready=0 for 3 cycles while valid[0]=valid[3]=1 -> all ready_out=0, message_out stays {01, 8'h3C}. When ready=1, the same cycle drains it and accepts input 3 (pointer=2 skips to 3), then input 0.
5. Wrap: ptr=3, only valid[0] and valid[1] asserted -> input 0 granted, ptr becomes 1, then input 1 granted.
6. Assert reset while valid_out=1 and ptr=2 -> valid_out=0 and message_out=0 immediately (asynchronously, before the next edge). After release with valid[1] and valid[2] high, input 1 wins.

Source files
------------

// File: rtl/arbiter_rr_merge.sv
// Round-robin N-to-1 merge: grants one valid input per cycle starting at a rotating
// priority pointer and registers {source index, payload} into a single output stage.
module arbiter_rr_merge #(
    parameter int p_nbits   = 32,
    parameter int p_ninputs = 8,
    localparam int c_iw     = $clog2(p_ninputs)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid       [0:p_ninputs-1],
    input  logic [p_nbits-1:0]      message_in  [0:p_ninputs-1],
    output logic                    ready_out   [0:p_ninputs-1],
    output logic                    valid_out,
    input  logic                    ready,
    output logic [p_nbits+c_iw-1:0] message_out
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high on the same channel; valid never waits on ready, ready may look at valid.

    logic                    out_valid_q;
    logic [p_nbits+c_iw-1:0] out_msg_q;
    logic [c_iw-1:0]         ptr_q;

    logic                    grant_valid;
    logic [c_iw-1:0]         grant_idx;
    logic [c_iw-1:0]         search_idx;
    logic                    can_load;
    logic                    accept;

    // Search from the pointer upward; c_iw-bit addition wraps since N is a power of two.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int k = 0; k < p_ninputs; k++) begin
            search_idx = ptr_q + c_iw'(k);
            if (!grant_valid && valid[search_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    assign can_load = !out_valid_q || ready;
    assign accept   = !reset && grant_valid && can_load;

    always_comb begin
        for (int i = 0; i < p_ninputs; i++) begin
            ready_out[i] = accept && (grant_idx == c_iw'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            ptr_q       <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_msg_q   <= {grant_idx, message_in[grant_idx]};
            ptr_q       <= grant_idx + c_iw'(1);
        end else if (out_valid_q && ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign valid_out   = out_valid_q;
    assign message_out = out_msg_q;

endmodule
